// File: rtl/adv_init_sequencer_pkg.sv
// adv_init_sequencer_pkg: shared FSM states, device address and ADV7513 register addresses
package adv_init_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HPD,
    S_ISSUE,
    S_WAIT_ACK,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [6:0] ADV_CHIP_ADDR = 7'h39;

  localparam logic [7:0] REG_POWER     = 8'h41;
  localparam logic [7:0] REG_FIX_98    = 8'h98;
  localparam logic [7:0] REG_FIX_9A    = 8'h9A;
  localparam logic [7:0] REG_FIX_9C    = 8'h9C;
  localparam logic [7:0] REG_FIX_9D    = 8'h9D;
  localparam logic [7:0] REG_FIX_A2    = 8'hA2;
  localparam logic [7:0] REG_FIX_A3    = 8'hA3;
  localparam logic [7:0] REG_FIX_E0    = 8'hE0;
  localparam logic [7:0] REG_FIX_F9    = 8'hF9;
  localparam logic [7:0] REG_VID_ID    = 8'h15;
  localparam logic [7:0] REG_VID_FMT   = 8'h16;
  localparam logic [7:0] REG_ASPECT    = 8'h17;
  localparam logic [7:0] REG_CSC       = 8'h18;
  localparam logic [7:0] REG_HDMI_MODE = 8'hAF;
  localparam logic [7:0] REG_GC_PKT    = 8'h40;
  localparam logic [7:0] REG_INT_MASK  = 8'h94;

endpackage

// File: rtl/adv_init_sequencer_if.sv
// adv_init_sequencer_if: req/ack register-write handshake towards the I2C master
interface adv_init_sequencer_if;
  logic       i2c_req;
  logic [6:0] i2c_chip;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_data;
  logic       i2c_ack;
  logic       i2c_err;

  modport master (output i2c_req, i2c_chip, i2c_reg, i2c_data, input i2c_ack, i2c_err);
  modport slave  (input i2c_req, i2c_chip, i2c_reg, i2c_data, output i2c_ack, i2c_err);
endinterface

// File: rtl/adv_init_sequencer_table.sv
// adv_init_table: combinational index -> {register, data} ADV7513 init table
module adv_init_table
  import adv_init_sequencer_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [7:0] index,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data
);

  logic [15:0] entry;

  // fixed table contents; indices past NUM_REGS read as zero below
  always_comb begin
    case (index)
      8'd0:    entry = {REG_POWER,     8'h10};
      8'd1:    entry = {REG_FIX_98,    8'h03};
      8'd2:    entry = {REG_FIX_9A,    8'hE0};
      8'd3:    entry = {REG_FIX_9C,    8'h30};
      8'd4:    entry = {REG_FIX_9D,    8'h61};
      8'd5:    entry = {REG_FIX_A2,    8'hA4};
      8'd6:    entry = {REG_FIX_A3,    8'hA4};
      8'd7:    entry = {REG_FIX_E0,    8'hD0};
      8'd8:    entry = {REG_FIX_F9,    8'h00};
      8'd9:    entry = {REG_VID_ID,    8'h00};
      8'd10:   entry = {REG_VID_FMT,   8'h30};
      8'd11:   entry = {REG_ASPECT,    8'h02};
      8'd12:   entry = {REG_CSC,       8'h46};
      8'd13:   entry = {REG_HDMI_MODE, 8'h06};
      8'd14:   entry = {REG_GC_PKT,    8'h80};
      8'd15:   entry = {REG_INT_MASK,  8'h80};
      default: entry = 16'h0000;
    endcase
  end

  assign {reg_addr, reg_data} = (int'(index) < NUM_REGS) ? entry : 16'h0000;

endmodule

// File: rtl/adv_init_sequencer.sv
// adv_init_sequencer: writes the ADV7513 init table after power-up and on every debounced hot-plug
module adv_init_sequencer
  import adv_init_sequencer_pkg::*;
#(
  parameter int         NUM_REGS            = 16,
  parameter logic [6:0] CHIP_ADDR           = ADV_CHIP_ADDR,
  parameter int         HPD_DEBOUNCE_CYCLES = 1_080_000,
  parameter int         RETRY_MAX           = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ready,
  input  logic                        hpd,
  adv_init_sequencer_if.master        i2c,
  output logic                        configured,
  output logic                        init_fail
);

  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;
  localparam int CW = HPD_DEBOUNCE_CYCLES > 1 ? $clog2(HPD_DEBOUNCE_CYCLES) : 1;
  localparam logic [IW-1:0] LAST    = IW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RMAX    = RW'(RETRY_MAX);
  localparam logic [CW-1:0] DB_LAST = CW'(HPD_DEBOUNCE_CYCLES - 1);

  state_t        state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [RW-1:0] retry, retry_d;
  logic          req, req_d;
  logic          cfg_d, fail_d;
  logic          unplug, unplug_d;
  logic [1:0]    hpd_sync;
  logic          hpd_deb;
  logic [CW-1:0] db_cnt;
  logic [7:0]    tbl_reg, tbl_data;

  adv_init_table #(.NUM_REGS(NUM_REGS)) u_table (
    .index    (8'(idx)),
    .reg_addr (tbl_reg),
    .reg_data (tbl_data)
  );

  assign i2c.i2c_req  = req;
  assign i2c.i2c_chip = CHIP_ADDR;
  assign i2c.i2c_reg  = tbl_reg;
  assign i2c.i2c_data = tbl_data;

  // synchronise raw HPD and only follow it after it has been stable for the debounce window
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hpd_sync <= 2'b00;
      hpd_deb  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      hpd_sync <= {hpd_sync[0], hpd};
      if (hpd_sync[1] == hpd_deb) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        hpd_deb <= hpd_sync[1];
        db_cnt  <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      retry      <= '0;
      req        <= 1'b0;
      configured <= 1'b0;
      init_fail  <= 1'b0;
      unplug     <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      retry      <= retry_d;
      req        <= req_d;
      configured <= cfg_d;
      init_fail  <= fail_d;
      unplug     <= unplug_d;
    end
  end

  // next state; a transaction in flight always completes, an unplug seen meanwhile is remembered
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    retry_d  = retry;
    req_d    = req;
    cfg_d    = configured;
    fail_d   = init_fail;
    unplug_d = unplug;
    if (!ready) begin
      state_d  = S_IDLE;
      req_d    = 1'b0;
      cfg_d    = 1'b0;
      fail_d   = 1'b0;
      unplug_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_d = S_WAIT_HPD;
        S_WAIT_HPD: begin
          if (hpd_deb) begin
            state_d = S_ISSUE;
            idx_d   = '0;
            retry_d = '0;
          end
        end
        S_ISSUE: begin
          if (!hpd_deb) state_d = S_WAIT_HPD;
          else begin
            req_d   = 1'b1;
            state_d = S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          unplug_d = unplug | ~hpd_deb;
          if (i2c.i2c_ack) begin
            req_d    = 1'b0;
            unplug_d = 1'b0;
            if (unplug || !hpd_deb) state_d = S_WAIT_HPD;
            else if (!i2c.i2c_err) begin
              if (idx == LAST) begin
                state_d = S_DONE;
                cfg_d   = 1'b1;
              end else begin
                idx_d   = idx + 1'b1;
                retry_d = '0;
                state_d = S_ISSUE;
              end
            end else if (retry == RMAX) begin
              state_d = S_FAIL;
              fail_d  = 1'b1;
            end else begin
              retry_d = retry + 1'b1;
              state_d = S_ISSUE;
            end
          end
        end
        S_DONE, S_FAIL: begin
          if (!hpd_deb) begin
            state_d = S_WAIT_HPD;
            cfg_d   = 1'b0;
            fail_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/adv_init_sequencer.md
Name: adv_init_sequencer

Overview:
- Sits directly downstream of the power-up delay block; consumes its `ready` output.
- Once ready is high and a debounced monitor hot-plug is present, walks a fixed register table and issues one write per entry to the ADV7513 via a req/ack handshake to the I2C master.
- Flags `configured` on success and `init_fail` after exhausted retries.
- Re-runs the full table on every monitor re-plug.

Parameters:
NUM_REGS, 16, number of table entries (1..256); index width = clog2(NUM_REGS), minimum 1
CHIP_ADDR, 7'h39, ADV7513 I2C main-map address driven on i2c_chip
HPD_DEBOUNCE_CYCLES, 1_080_000, consecutive stable synchronised HPD cycles required before the debounced level changes (20 ms at 54 MHz)
RETRY_MAX, 3, re-attempts of one entry after NAK before failing

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low; clears all state
ready  in  1  power-up delay complete; level, synchronous to clock
hpd  in  1  raw hot-plug detect, asynchronous; 2-flop synchronised internally
i2c_req  out  1  write request; held high until i2c_ack
i2c_chip  out  7  device address, constant CHIP_ADDR
i2c_reg  out  8  register address of current entry
i2c_data  out  8  register data of current entry
i2c_ack  in  1  one-cycle pulse: transaction finished
i2c_err  in  1  valid only with i2c_ack; 1 = NAK
configured  out  1  all NUM_REGS entries written OK since last plug
init_fail  out  1  an entry NAKed RETRY_MAX+1 times

Behaviour:
- Reset (async, low): state IDLE, index 0, retry 0, i2c_req 0, configured 0, init_fail 0, sync flops 0, debounced hpd 0, debounce counter 0.
- HPD path: 2-flop sync, then debounce counter. It resets whenever the synced value equals the debounced level; the debounced level takes the synced value when the counter reaches HPD_DEBOUNCE_CYCLES-1. Pulses shorter than HPD_DEBOUNCE_CYCLES are ignored.
- i2c_reg/i2c_data come combinationally from the sub-module table at the current index. They are stable while i2c_req is high.
- States:
  - IDLE: wait for ready=1 → WAIT_HPD.
  - WAIT_HPD: wait for debounced hpd=1 → ISSUE; clear index and retry.
  - ISSUE: set i2c_req=1 → WAIT_ACK.
  - WAIT_ACK: hold req. On i2c_ack: req→0 the next cycle.
    - err=0 and index=NUM_REGS-1 → DONE (configured←1).
    - err=0 otherwise → index+1, retry←0, → ISSUE.
    - err=1 and retry<RETRY_MAX → retry+1, → ISSUE (same index).
    - err=1 and retry=RETRY_MAX → FAIL (init_fail←1).
  - DONE: hold configured=1.
  - FAIL: hold init_fail=1.
- Minimum spacing: one idle cycle (ISSUE) between ack and the next req rising edge.
- Debounced hpd falling edge:
  - In ISSUE, DONE or FAIL → WAIT_HPD next cycle; configured←0, init_fail←0.
  - In WAIT_ACK, the current transaction is never aborted. The fall is latched; on i2c_ack, go to WAIT_HPD regardless of err.
- ready=0 in any state → IDLE next cycle, i2c_req←0, flags cleared. In-flight ack is ignored; the I2C master shares the reset.
- i2c_ack outside WAIT_ACK is ignored.
- Index never exceeds NUM_REGS-1. No wrap.

Decomposition:
- Shared package: state enum, default CHIP_ADDR, ADV7513 register-address constants.
- One sub-module `adv_init_table`: purely combinational index→{reg[7:0], data[7:0]} lookup. Parameterised by NUM_REGS; out-of-range index returns {8'h00, 8'h00}.

Test Plan:
Bench settings: NUM_REGS=3, HPD_DEBOUNCE_CYCLES=4, RETRY_MAX=2; ack model pulses i2c_ack 5 cycles after req rises.
- Nominal: ready=1, hpd=1 from start → exactly 3 req/ack pairs with table entries 0,1,2 in order; configured=1 one cycle after the 3rd ack; init_fail=0.
- HPD glitch: hpd high 3 cycles then low → no req ever. Then hpd high 4+2 cycles → first req rises.
- NAK retry: err=1 on first two acks of entry 1, then 0 → entry 1 issued 3 times, configured=1. Variant with err=1 on all attempts of entry 1 → 3 attempts, init_fail=1, no entry 2 req.
- Unplug mid-transaction: debounced hpd falls while in WAIT_ACK on entry 0 → req stays high until ack, then state WAIT_HPD and configured=0. Re-plug → restart at entry 0.
- Reset mid-operation: assert reset low asynchronously while req=1 → i2c_req, configured, init_fail read 0 before the next clock edge. Release → sequence restarts from IDLE.
- ready drop: ready 1→0 in DONE → configured=0 the next cycle, state IDLE, no req until ready returns.
